key_expander: RTL and testbench

Iterative AES key-schedule engine that sits directly upstream of the round datapath (`Cipher`). It turns an N-bit cipher key into the packed `(Nr+1)`-round-key bus that the round datapath consumes on its `word` input. The block produces one 32-bit schedule word per clock, in the order given by FIPS-197 §5.2. It signals completion with a pulse and a level-valid flag, so the cipher's enable can be gated on it.

---
 rtl/key_expander.sv | 278 +++++++++++++++++++++++++++
 tb/tb_key_expander.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expander.sv
// ---------------------------------------------------------------------------
// key_expander
//
// Iterative AES key-schedule engine (AES-128/192/256). Produces one 32-bit
// schedule word per clock and presents the whole (Nr+1)-round-key schedule
// on a packed bus for the downstream round datapath.
//
// Parameters
//   N   : key width in bits (32*Nk)
//   Nr  : number of rounds (Nk+6)
//   Nk  : key length in 32-bit words (4, 6 or 8)
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : synchronous active-low reset
//   start     : request an expansion of key_in (accepted only in IDLE)
//   key_in    : cipher key, byte 0 at the MSB end
//   busy      : high while schedule words are being generated
//   done      : one-cycle pulse on the edge that writes the last word
//   key_valid : high from done until the next accepted start or reset
//   word      : packed schedule, w[i] at [128*(Nr+1)-1-32*i -: 32]
//
// Build option
//   KEY_EXPANSION_SHADOW_EN : when defined, words are generated into a
//   working register and `word` is a shadow copy taken on the done edge,
//   so the previous schedule stays visible during a re-expansion. When
//   undefined, `word` is the working register itself.
// ---------------------------------------------------------------------------
module key_expander #(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N-1:0]            key_in,
    output logic                    busy,
    output logic                    done,
    output logic                    key_valid,
    output logic [128*(Nr+1)-1:0]   word
);

    localparam int WW   = 128 * (Nr + 1);   // schedule bus width
    localparam int NW   = 4 * (Nr + 1);     // total schedule words
    localparam int IDXW = 6;                // word index width (NW <= 60)
    localparam int LSBW = $clog2(WW);       // bit-offset width into the bus

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // GF(2^8) helpers and the S-box. The S-box is computed as the
    // multiplicative inverse followed by the AES affine transform rather
    // than a 256-entry table.
    // -----------------------------------------------------------------------
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p = p ^ (b[k] ? x : 8'h00);
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_r;
    state_t             state_s;
    logic               load_s;
    logic               step_s;
    logic               last_s;

    logic [IDXW-1:0]    idx_r;      // index i of the word being written
    logic [2:0]         mod_r;      // i mod Nk
    logic [7:0]         rcon_r;
    // Sliding window of the last Nk words: [31:0] is w[i-1], the top word
    // is w[i-Nk]. Avoids wide read muxes on the schedule bus.
    logic [N-1:0]       win_r;
    logic [WW-1:0]      sched_r;    // working schedule register

    logic               busy_r;
    logic               done_r;
    logic               valid_r;

    logic [31:0]        temp_s;
    logic [31:0]        sbox_in_s;
    logic [31:0]        sub_s;
    logic [31:0]        mixed_s;
    logic [31:0]        new_w_s;
    logic [LSBW-1:0]    wr_lsb_s;

    // Next-state and control strobes for the IDLE/EXPAND controller
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_s = EXPAND;
                end else begin
                    state_s = IDLE;
                end
            end
            EXPAND: begin
                step_s = 1'b1;
                if (idx_r == IDXW'(NW - 1)) begin
                    last_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = EXPAND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Word generation datapath: temp transform and new schedule word
    always_comb begin
        temp_s    = win_r[31:0];
        sbox_in_s = temp_s;
        sub_s     = 32'h0000_0000;
        mixed_s   = temp_s;
        if (mod_r == 3'd0) begin
            // RotWord before SubWord on the first word of each key block
            sbox_in_s = {temp_s[23:0], temp_s[31:24]};
        end else begin
            sbox_in_s = temp_s;
        end
        // Single shared set of four S-box lookups
        sub_s = sub_word(sbox_in_s);
        if (mod_r == 3'd0) begin
            mixed_s = sub_s ^ {rcon_r, 24'h00_0000};
        end else if ((Nk == 8) && (mod_r == 3'd4)) begin
            mixed_s = sub_s;
        end else begin
            mixed_s = temp_s;
        end
        new_w_s  = win_r[N-1 -: 32] ^ mixed_s;
        wr_lsb_s = LSBW'(WW - 32 - 32 * int'(idx_r));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Index, modulo counter, round constant and sliding word window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r  <= {IDXW{1'b0}};
            mod_r  <= 3'd0;
            rcon_r <= 8'h01;
            win_r  <= {N{1'b0}};
        end else if (load_s) begin
            idx_r  <= IDXW'(Nk);
            mod_r  <= 3'd0;
            rcon_r <= 8'h01;
            win_r  <= key_in;
        end else if (step_s) begin
            idx_r  <= idx_r + 6'd1;
            mod_r  <= (mod_r == 3'(Nk - 1)) ? 3'd0 : (mod_r + 3'd1);
            rcon_r <= (mod_r == 3'd0) ? gf_xtime(rcon_r) : rcon_r;
            win_r  <= {win_r[N-33:0], new_w_s};
        end else begin
            idx_r  <= idx_r;
            mod_r  <= mod_r;
            rcon_r <= rcon_r;
            win_r  <= win_r;
        end
    end

    // Working schedule register: key loaded in one cycle, then one word per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sched_r <= {WW{1'b0}};
        end else if (load_s) begin
            sched_r[WW-1 -: N] <= key_in;
        end else if (step_s) begin
            sched_r[wr_lsb_s +: 32] <= new_w_s;
        end else begin
            sched_r <= sched_r;
        end
    end

    // Status flags: busy, done pulse and key_valid level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (load_s) begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (last_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            valid_r <= 1'b1;
        end else begin
            busy_r  <= busy_r;
            done_r  <= 1'b0;
            valid_r <= valid_r;
        end
    end

`ifdef KEY_EXPANSION_SHADOW_EN
    logic [WW-1:0] word_r;

    // Shadow copy of the finished schedule; the final word is taken from
    // the datapath because it lands in sched_r on this same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_r <= {WW{1'b0}};
        end else if (last_s) begin
            word_r <= {sched_r[WW-1:32], new_w_s};
        end else begin
            word_r <= word_r;
        end
    end

    assign word = word_r;
`else
    assign word = sched_r;
`endif

    assign busy      = busy_r;
    assign done      = done_r;
    assign key_valid = valid_r;

endmodule

// File: tb/tb_key_expander.sv
// ---------------------------------------------------------------------------
// tb_key_expander
//
// Directed bench for key_expander using FIPS-197 key-schedule vectors for
// AES-128, AES-192 and AES-256, plus control scenarios (ignored start,
// back-to-back start, mid-expansion reset, shadow behaviour).
// ---------------------------------------------------------------------------
module tb_key_expander;

    localparam int W128 = 128 * 11;
    localparam int W192 = 128 * 13;
    localparam int W256 = 128 * 15;

    localparam logic [127:0] KA       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KA_LAST  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [31:0]  KA_W4    = 32'ha0fafe17;
    localparam logic [127:0] KB       = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KB_LAST  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [31:0]  KB_W4    = 32'hd6aa74fd;
    localparam logic [191:0] K192     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] K192_LAST = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [31:0]  K192_W6  = 32'hfe0c91f7;
    localparam logic [255:0] K256     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_LAST = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [31:0]  K256_W8  = 32'h9ba35411;

    logic               clk;
    logic               rst_n;

    logic               start128;
    logic [127:0]       key128;
    logic               busy128;
    logic               done128;
    logic               kv128;
    logic [W128-1:0]    word128;

    logic               start192;
    logic [191:0]       key192;
    logic               busy192;
    logic               done192;
    logic               kv192;
    logic [W192-1:0]    word192;

    logic               start256;
    logic [255:0]       key256;
    logic               busy256;
    logic               done256;
    logic               kv256;
    logic [W256-1:0]    word256;

    int checks;
    int errors;

    key_expander #(.N(128), .Nr(10), .Nk(4)) dut128 (
        .clk(clk), .rst_n(rst_n), .start(start128), .key_in(key128),
        .busy(busy128), .done(done128), .key_valid(kv128), .word(word128)
    );

    key_expander #(.N(192), .Nr(12), .Nk(6)) dut192 (
        .clk(clk), .rst_n(rst_n), .start(start192), .key_in(key192),
        .busy(busy192), .done(done192), .key_valid(kv192), .word(word192)
    );

    key_expander #(.N(256), .Nr(14), .Nk(8)) dut256 (
        .clk(clk), .rst_n(rst_n), .start(start256), .key_in(key256),
        .busy(busy256), .done(done256), .key_valid(kv256), .word(word256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // steps until the selected DUT raises done; cyc = edges waited, -1 on timeout
    task automatic wait_done(input int sel, output int cyc);
        cyc = -1;
        for (int n = 1; n <= 200; n++) begin
            step();
            if ((sel == 0 && done128) || (sel == 1 && done192) || (sel == 2 && done256)) begin
                cyc = n;
                break;
            end
        end
    endtask

    // applies start with the given key to the AES-128 DUT for one edge
    task automatic accept128(input logic [127:0] k);
        key128   = k;
        start128 = 1'b1;
        step();
        start128 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({busy128, done128, kv128} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags128 got %b want 000", {busy128, done128, kv128});
        end
        checks++;
        if (word128 !== {W128{1'b0}}) begin
            errors++;
            $display("FAIL reset_word128 got %h want 0", word128);
        end
        checks++;
        if ({busy192, kv192, busy256, kv256} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags192_256 got %b want 0000", {busy192, kv192, busy256, kv256});
        end
        checks++;
        if (word192[127:0] !== 128'h0 || word256[127:0] !== 128'h0) begin
            errors++;
            $display("FAIL reset_word192_256 got %h %h want 0", word192[127:0], word256[127:0]);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_aes128();
        int cyc;
        accept128(KA);
        checks++;
        if ({busy128, kv128, done128} !== 3'b100) begin
            errors++;
            $display("FAIL aes128_accept_flags got %b want 100", {busy128, kv128, done128});
        end
        wait_done(0, cyc);
        checks++;
        if (cyc != 40) begin
            errors++;
            $display("FAIL aes128_latency got %0d want 40", cyc);
        end
        checks++;
        if ({busy128, kv128} !== 2'b01) begin
            errors++;
            $display("FAIL aes128_done_flags got %b want 01", {busy128, kv128});
        end
        checks++;
        if (word128[127:0] !== KA_LAST) begin
            errors++;
            $display("FAIL aes128_last got %h want %h", word128[127:0], KA_LAST);
        end
        checks++;
        if (word128[W128-129 -: 32] !== KA_W4) begin
            errors++;
            $display("FAIL aes128_w4 got %h want %h", word128[W128-129 -: 32], KA_W4);
        end
        checks++;
        if (word128[W128-1 -: 128] !== KA) begin
            errors++;
            $display("FAIL aes128_round0 got %h want %h", word128[W128-1 -: 128], KA);
        end
        step();
        checks++;
        if ({done128, kv128} !== 2'b01) begin
            errors++;
            $display("FAIL aes128_done_pulse got %b want 01", {done128, kv128});
        end
    endtask

    task automatic test_aes192();
        int cyc;
        key192   = K192;
        start192 = 1'b1;
        step();
        start192 = 1'b0;
        wait_done(1, cyc);
        checks++;
        if (cyc != 46) begin
            errors++;
            $display("FAIL aes192_latency got %0d want 46", cyc);
        end
        checks++;
        if (word192[127:0] !== K192_LAST) begin
            errors++;
            $display("FAIL aes192_last got %h want %h", word192[127:0], K192_LAST);
        end
        checks++;
        if (word192[W192-1-192 -: 32] !== K192_W6) begin
            errors++;
            $display("FAIL aes192_w6 got %h want %h", word192[W192-1-192 -: 32], K192_W6);
        end
        checks++;
        if (word192[W192-1 -: 192] !== K192 || kv192 !== 1'b1) begin
            errors++;
            $display("FAIL aes192_round0 got %h kv %b want %h kv 1", word192[W192-1 -: 192], kv192, K192);
        end
    endtask

    task automatic test_aes256();
        int cyc;
        key256   = K256;
        start256 = 1'b1;
        step();
        start256 = 1'b0;
        wait_done(2, cyc);
        checks++;
        if (cyc != 52) begin
            errors++;
            $display("FAIL aes256_latency got %0d want 52", cyc);
        end
        checks++;
        if (word256[127:0] !== K256_LAST) begin
            errors++;
            $display("FAIL aes256_last got %h want %h", word256[127:0], K256_LAST);
        end
        checks++;
        if (word256[W256-1-256 -: 32] !== K256_W8) begin
            errors++;
            $display("FAIL aes256_w8 got %h want %h", word256[W256-1-256 -: 32], K256_W8);
        end
        checks++;
        if (word256[W256-1 -: 256] !== K256 || kv256 !== 1'b1) begin
            errors++;
            $display("FAIL aes256_round0 got %h kv %b want %h kv 1", word256[W256-1 -: 256], kv256, K256);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        accept128(KA);
        wait_done(0, cyc);
        checks++;
        if (cyc != 40) begin
            errors++;
            $display("FAIL b2b_first_latency got %0d want 40", cyc);
        end
        // start raised in the done cycle, accepted on the very next edge
        accept128(KB);
        key128 = 128'hffffffffffffffffffffffffffffffff;
        checks++;
        if ({busy128, kv128, done128} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_accept_flags got %b want 100", {busy128, kv128, done128});
        end
        wait_done(0, cyc);
        checks++;
        if (cyc != 40) begin
            errors++;
            $display("FAIL b2b_second_latency got %0d want 40", cyc);
        end
        checks++;
        if (word128[127:0] !== KB_LAST || word128[W128-129 -: 32] !== KB_W4) begin
            errors++;
            $display("FAIL b2b_schedule got %h w4 %h want %h w4 %h",
                     word128[127:0], word128[W128-129 -: 32], KB_LAST, KB_W4);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        int pulses;
        accept128(KA);
        repeat (10) step();
        key128   = KB;
        start128 = 1'b1;
        step();
        start128 = 1'b0;
        wait_done(0, cyc);
        checks++;
        if (cyc + 11 != 40) begin
            errors++;
            $display("FAIL ignored_latency got %0d want 40", cyc + 11);
        end
        pulses = (cyc > 0) ? 1 : 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (done128) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ignored_done_pulses got %0d want 1", pulses);
        end
        checks++;
        if (word128[127:0] !== KA_LAST) begin
            errors++;
            $display("FAIL ignored_schedule got %h want %h", word128[127:0], KA_LAST);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        accept128(KA);
        repeat (20) step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({busy128, done128, kv128} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_flags got %b want 000", {busy128, done128, kv128});
        end
        checks++;
        if (word128 !== {W128{1'b0}}) begin
            errors++;
            $display("FAIL midreset_word got %h want 0", word128);
        end
        rst_n = 1'b1;
        accept128(KB);
        wait_done(0, cyc);
        checks++;
        if (cyc != 40) begin
            errors++;
            $display("FAIL midreset_latency got %0d want 40", cyc);
        end
        checks++;
        if (word128[127:0] !== KB_LAST || word128[W128-1 -: 128] !== KB) begin
            errors++;
            $display("FAIL midreset_schedule got %h round0 %h want %h round0 %h",
                     word128[127:0], word128[W128-1 -: 128], KB_LAST, KB);
        end
    endtask

    task automatic test_shadow();
        int cyc;
        int bad;
        accept128(KA);
        wait_done(0, cyc);
        accept128(KB);
        checks++;
        if (kv128 !== 1'b0) begin
            errors++;
            $display("FAIL shadow_kv_drop got %b want 0", kv128);
        end
`ifdef KEY_EXPANSION_SHADOW_EN
        bad = 0;
        cyc = -1;
        for (int n = 1; n <= 200; n++) begin
            if (word128[127:0] !== KA_LAST || word128[W128-1 -: 128] !== KA) bad++;
            step();
            if (done128) begin
                cyc = n;
                break;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL shadow_hold got %0d bad cycles want 0", bad);
        end
`else
        bad = 0;
        checks++;
        if (word128[W128-1 -: 128] !== KB) begin
            errors++;
            $display("FAIL noshadow_load got %h want %h", word128[W128-1 -: 128], KB);
        end
        wait_done(0, cyc);
        cyc = cyc + bad;
`endif
        checks++;
        if (cyc != 40) begin
            errors++;
            $display("FAIL shadow_latency got %0d want 40", cyc);
        end
        checks++;
        if (word128[127:0] !== KB_LAST || word128[W128-1 -: 128] !== KB) begin
            errors++;
            $display("FAIL shadow_switch got %h round0 %h want %h round0 %h",
                     word128[127:0], word128[W128-1 -: 128], KB_LAST, KB);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start128 = 1'b0;
        start192 = 1'b0;
        start256 = 1'b0;
        key128   = 128'h0;
        key192   = 192'h0;
        key256   = 256'h0;
        #1;
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_shadow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
